// File: rtl/fir_coeff_loader.sv
// fir_coeff_loader: shadow RAM for the symmetric half FIR coefficient set, streamed serially into fir_filter_iq on command
module fir_coeff_loader #(
   parameter int COEFF_WIDTH = 16,
   parameter int NUM_COEFFS  = 4096,
   parameter int ADDR_WIDTH  = $clog2(NUM_COEFFS/2)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   wr_stb,
   input  logic [ADDR_WIDTH-1:0]  wr_addr,
   input  logic [COEFF_WIDTH-1:0] wr_data,
   input  logic                   load_start,
   output logic [COEFF_WIDTH-1:0] coeff_out,
   output logic                   reload_coeff,
   output logic                   busy,
   output logic                   done,
   output logic                   wr_err
);
   localparam int HALF = NUM_COEFFS/2;
   localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(HALF-1);
   typedef enum logic [1:0] {IDLE, PRIME, STREAM} state_t;
   state_t state, state_nxt;
   logic [COEFF_WIDTH-1:0] ram [HALF];
   logic [ADDR_WIDTH-1:0] rd_addr, rd_addr_nxt;
   logic rd_en, last, wr_ok;
   always_comb begin
      state_nxt = state;
      rd_addr_nxt = rd_addr;
      rd_en = 1'b0;
      last = state == STREAM && rd_addr == LAST;
      wr_ok = wr_stb && state == IDLE && int'(wr_addr) < HALF;
      case (state)
         IDLE: state_nxt = load_start ? PRIME : IDLE;
         PRIME: begin
            rd_en = 1'b1;
            state_nxt = STREAM;
         end
         STREAM: begin
            rd_en = !last;
            rd_addr_nxt = last ? '0 : rd_addr + 1'b1;
            state_nxt = last ? IDLE : STREAM;
         end
         default: state_nxt = IDLE;
      endcase
   end
   // rd_addr tracks the index currently on coeff_out; the read ahead fetches rd_addr_nxt
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state <= IDLE;
         rd_addr <= '0;
         coeff_out <= '0;
         done <= 1'b0;
         wr_err <= 1'b0;
      end else begin
         state <= state_nxt;
         rd_addr <= rd_addr_nxt;
         if (rd_en) coeff_out <= ram[rd_addr_nxt];
         done <= last;
         wr_err <= wr_stb && !wr_ok;
      end
   always_ff @(posedge clk)
      if (wr_ok) ram[wr_addr] <= wr_data;
   assign reload_coeff = state != STREAM;
   assign busy = state != IDLE;
endmodule

// File: tb/tb_fir_coeff_loader.sv
// tb_fir_coeff_loader: scoreboard bench with an edge-count reference model of the coefficient loader
module tb_fir_coeff_loader;
   localparam int CW = 16;
   localparam int NC = 8;
   localparam int H  = NC/2;
   localparam int AW = $clog2(H);
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic wr_stb = 1'b0;
   logic [AW-1:0] wr_addr = '0;
   logic [CW-1:0] wr_data = '0;
   logic load_start = 1'b0;
   logic [CW-1:0] coeff_out;
   logic reload_coeff, busy, done, wr_err;
   fir_coeff_loader #(.COEFF_WIDTH(CW), .NUM_COEFFS(NC)) dut (
      .clk(clk), .reset(reset), .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data),
      .load_start(load_start), .coeff_out(coeff_out), .reload_coeff(reload_coeff),
      .busy(busy), .done(done), .wr_err(wr_err)
   );
   always #5 clk = ~clk;
   // model: k counts edges since the accepted load_start (-1 when no load has been seen)
   int k = -1;
   logic e_err = 1'b0;
   logic [CW-1:0] mem [H];
   logic [CW-1:0] exp_q [$];
   logic [CW-1:0] hold_val = '0;
   int n_chk = 0, n_pass = 0;
   function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
   endfunction
   task automatic tick();
      bit bz;
      @(posedge clk);
      bz = k >= 0 && k <= H;
      if (reset) begin
         k = -1;
         e_err = 1'b0;
      end else begin
         e_err = wr_stb && (bz || int'(wr_addr) >= H);
         if (wr_stb && !e_err) mem[wr_addr] = wr_data;
         k = bz ? k + 1 : -1;
         if (!bz && load_start) begin
            k = 0;
            for (int i = 0; i < H; i++) exp_q.push_back(mem[i]);
         end
      end
      #1;
      wr_stb = 1'b0;
      load_start = 1'b0;
   endtask
   task automatic drive(bit s, logic [AW-1:0] a, logic [CW-1:0] d, bit ls);
      wr_stb = s;
      wr_addr = a;
      wr_data = d;
      load_start = ls;
      tick();
   endtask
   always @(negedge clk) begin
      logic [CW-1:0] e;
      if (reset) begin
         exp_q.delete();
         hold_val = '0;
      end
      chk("busy", busy, k >= 0 && k <= H);
      chk("reload_coeff", reload_coeff, !(k >= 1 && k <= H));
      chk("done", done, k == H + 1);
      chk("wr_err", wr_err, e_err);
      if (!reload_coeff) begin
         if (exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL coeff_stream: got %h with no coefficient expected at %0t", coeff_out, $time);
         end else begin
            e = exp_q.pop_front();
            chk("coeff_stream", coeff_out, e);
            hold_val = e;
         end
      end else chk("coeff_hold", coeff_out, hold_val);
   end
   initial begin
      tick();
      tick();
      reset = 1'b0;
      drive(1, 0, 16'h0001, 0);
      drive(1, 1, 16'h7FFF, 0);
      drive(1, 2, 16'h8000, 0);
      drive(1, 3, 16'h1234, 0);
      drive(0, 0, 0, 1);
      repeat (8) tick();
      drive(0, 0, 0, 1);
      drive(1, 2, 16'hAAAA, 0);
      drive(1, 2, 16'hAAAA, 0);
      repeat (6) tick();
      drive(0, 0, 0, 1);
      repeat (7) tick();
      drive(1, 0, 16'h5555, 1);
      repeat (7) tick();
      drive(0, 0, 0, 1);
      for (int i = 0; i < 7; i++) drive(0, 0, 0, k == 3);
      drive(0, 0, 0, 1);
      tick();
      tick();
      #1 reset = 1'b1;
      k = -1;
      e_err = 1'b0;
      #1;
      chk("async_reload", reload_coeff, 1);
      chk("async_busy", busy, 0);
      chk("async_coeff", coeff_out, 0);
      tick();
      reset = 1'b0;
      drive(0, 0, 0, 1);
      for (int i = 0; i < 12; i++) drive(0, 0, 0, k == H + 1);
      repeat (3) tick();
      for (int i = 0; i < 400; i++)
         drive($urandom_range(0, 3) == 0, AW'($urandom_range(0, H - 1)), CW'($urandom), $urandom_range(0, 9) == 0);
      repeat (8) tick();
      chk("queue_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/fir_coeff_loader.md
# fir_coeff_loader

Coefficient source for `fir_filter_iq`: accepts host writes of the symmetric half coefficient set into an internal shadow RAM. On command it streams the set serially onto the filter's `coeff_in` / `reload_coeff` pins, one coefficient per clock. It sits between the settings-bus register decode and the FIR. This lets filter taps be changed at run time without the simulation-only memory preload.

## Interface
- `COEFF_WIDTH`, 16, coefficient width in bits.
- `NUM_COEFFS`, 4096, full filter length; must be even. The block stores and streams `NUM_COEFFS/2` values (symmetric half).
- `ADDR_WIDTH`, `$clog2(NUM_COEFFS/2)`, shadow RAM address width.

- `clk` in 1: single clock; all logic is on the rising edge.
- `reset` in 1: asynchronous, active-high; clears all state except RAM contents.
- `wr_stb` in 1: host write strobe, one coefficient per cycle.
- `wr_addr` in `ADDR_WIDTH`: shadow RAM write index.
- `wr_data` in `COEFF_WIDTH`: coefficient value, two's complement.
- `load_start` in 1: single-cycle pulse that begins a stream.
- `coeff_out` out `COEFF_WIDTH`: to filter `coeff_in`.
- `reload_coeff` out 1: to filter `reload_coeff`. Low means the filter shifts in `coeff_out` this cycle; high means the coefficients are frozen.
- `busy` out 1: high from acceptance of `load_start` until the last coefficient is presented.
- `done` out 1: one-cycle pulse when reload completes.
- `wr_err` out 1: one-cycle pulse when a write is dropped.

## Operation
- The shadow RAM holds `NUM_COEFFS/2` × `COEFF_WIDTH` bits in a 1R1W array with registered read. Contents survive `reset` and are undefined at power-up.
- FSM states:
  - IDLE: `reload_coeff`=1, `busy`=0. `load_start` → PRIME.
  - PRIME: one cycle; issues read of address 0; `busy`=1. Unconditionally → STREAM.
  - STREAM: each cycle presents the registered read data on `coeff_out` with `reload_coeff`=0, and advances the read address. After index `NUM_COEFFS/2-1` is presented → IDLE.
- Stream order is ascending address: 0, 1, …, `NUM_COEFFS/2-1`. Exactly `NUM_COEFFS/2` cycles have `reload_coeff`=0, with no gaps. There is no backpressure; the filter always accepts.
- Writes:
  - In IDLE, a write with `wr_stb`=1 takes effect at the next edge.
  - In PRIME or STREAM, writes are dropped, RAM is unchanged, and `wr_err` pulses the following cycle.
  - `wr_addr` ≥ `NUM_COEFFS/2` (non-power-of-two sizes) is dropped with `wr_err` in any state.
- `load_start` while `busy`=1 is ignored (no restart, no error).
- `load_start` and `wr_stb` in the same IDLE cycle: the write commits first, and the stream reads the new value.
- The read address counter is `ADDR_WIDTH` bits. Termination uses a compare against `NUM_COEFFS/2-1`, not counter wrap.

## Timing
- Reset values:
  - `coeff_out`=0, `reload_coeff`=1, `busy`=0, `done`=0, `wr_err`=0.
  - FSM=IDLE, read address 0.
- Relative to the edge E0 at which `load_start`=1 is sampled:
  - After E0: `busy`=1.
  - After E0+1: `reload_coeff`=0 and `coeff_out`=RAM[0].
  - After E0+k: `coeff_out`=RAM[k-1], for k = 1…`NUM_COEFFS/2`.
  - After E0+`NUM_COEFFS/2`+1: `reload_coeff`=1, `busy`=0, `done`=1 for one cycle.
- `coeff_out` holds the last streamed coefficient until the next stream or reset.
- Total command-to-frozen latency is `NUM_COEFFS/2`+2 cycles; back-to-back loads cannot overlap.
- Reset asserted mid-stream:
  - Outputs go to reset values immediately, independent of `clk`; `reload_coeff` returns high at once.
  - No `done` pulse is issued, and RAM is retained.
  - A subsequent `load_start` restarts from address 0.
- `wr_err` pulses after the edge that sampled the offending `wr_stb`; each dropped write produces its own pulse.

## Test plan
Bench uses `NUM_COEFFS`=8, so 4 stored coefficients.
- Basic load: write 0x0001, 0x7FFF, 0x8000, 0x1234 to addresses 0–3, then pulse `load_start`. Require `reload_coeff` low for exactly 4 cycles starting 2 edges after the pulse, with `coeff_out` sequence 0x0001, 0x7FFF, 0x8000, 0x1234. Then `reload_coeff`=1, `done` a single pulse, and `coeff_out` holding 0x1234.
- Write during stream: during the stream, write 0xAAAA to address 2. Require `wr_err` pulse and address 2 still 0x8000 on a second load.
- Same-cycle write and start: write 0x5555 to address 0 together with `load_start` in IDLE. Require first streamed value 0x5555.
- Ignored restart: pulse `load_start` at the third STREAM cycle. Require still exactly 4 low cycles and one `done`.
- Reset mid-stream: assert `reset` after the second coefficient. Require `reload_coeff`=1, `busy`=0 and `coeff_out`=0 asynchronously, with no `done`. A new load then streams the original 4 values from address 0.
- Back-to-back loads: pulse `load_start` on the cycle `done` is high. Require the second stream to start 2 edges later with an identical sequence.
